hazard_controller: RTL
======================

Name: hazard_controller

Overview:
Sequences the five-stage pipeline registers (F/D, D/E, E/M, M/W) by generating per-stage stall and flush controls plus EX-stage operand forwarding selects.
Handles three hazard classes:
- load-use hazards
- taken-branch flushes
- variable-latency data-memory waits, using a req/ready handshake with a wait FSM

Holds a one-entry bypass register, so a result retired from WB during a memory wait is still forwardable to EX.

Parameters:
WIDTH, 32, datapath/result width
MEM_TIMEOUT, 255, wait cycles before MemTimeout asserts (1..65535)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
Rs1D  in  5  rs1 index, decode
Rs2D  in  5  rs2 index, decode
Rs1E  in  5  rs1 index, execute
Rs2E  in  5  rs2 index, execute
RdE  in  5  destination, execute
RdM  in  5  destination, memory
RdW  in  5  destination, writeback
ResultSrcE  in  1  EX instruction is a load
RegWriteM  in  1  M instruction writes the register file
RegWriteW  in  1  W instruction writes the register file
PCSrcE  in  1  branch/jump taken in EX
MemReqM  in  1  M instruction accesses data memory
MemReadyM  in  1  data memory completes this cycle
ResultW  in  WIDTH  writeback result
ForwardAE  out  2  operand A select: 00 regfile, 01 W, 10 M, 11 held
ForwardBE  out  2  operand B select, same encoding
HeldResultE  out  WIDTH  bypass-register data
StallF  out  1  PC enable low
StallD  out  1  F/D hold
StallE  out  1  D/E hold
StallM  out  1  E/M hold
FlushD  out  1  F/D bubble
FlushE  out  1  D/E bubble
FlushW  out  1  M/W bubble (forces RegWriteW=0 next cycle)
MemTimeout  out  1  sticky memory-wait timeout flag
StallCount  out  32  memory plus load-use stall cycles (feature)
FlushCount  out  32  branch flush events (feature)

Behaviour:
- Reset (rst_n=0 at edge):
  - state=RUN, wait counter=0, MemTimeout=0, hold valid=0, HeldResultE=0, perf counters=0.
  - While rst_n is low, all Stall*=0, FlushD/FlushE/FlushW=1, Forward*=00.
- memStall (combinational) = (state==RUN & MemReqM & !MemReadyM) | (state==WAIT & !MemReadyM).
  - This asserts in the same cycle the request is seen; there is no added latency.
- FSM:
  - RUN->WAIT when MemReqM & !MemReadyM.
  - WAIT->RUN when MemReadyM.
  - RUN stays in RUN when MemReqM & MemReadyM (single-cycle access).
- memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Branch and load-use are ignored. PCSrcE is held in the stalled EX and is re-evaluated on the release cycle.
- lwStall = ResultSrcE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Priority: memStall > PCSrcE > lwStall.
  - PCSrcE alone: FlushD=FlushE=1.
  - PCSrcE with lwStall: the branch wins. Flush only, no stall.
  - lwStall alone: StallF=StallD=1, FlushE=1.
- Wait counter:
  - Increments each WAIT cycle, saturating at MEM_TIMEOUT.
  - Reaching MEM_TIMEOUT sets MemTimeout (sticky until reset). The FSM keeps waiting.
  - The counter clears on WAIT->RUN.
- Bypass register:
  - On the first memStall cycle (RUN with memStall), capture ResultW/RdW/RegWriteW. hold valid = RegWriteW & RdW!=0.
  - Hold valid clears at any edge where StallE=0.
- Forward select, per operand, with Rs = Rs1E or Rs2E:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs.
  - else 11 if hold valid & heldRd==Rs.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs.
  - else 00.
- x0 is never forwarded.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - StallCount increments on every cycle with memStall or lwStall (an actually applied stall).
  - FlushCount increments on every applied branch flush.
  - Both are 32-bit and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are present.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, FWD_HOLD=2'b11.
  - hz_state_t enum: RUN, WAIT.
  - REG_ZERO=5'd0.
- Sub-module hazard_fwd_sel: combinational per-operand forward priority logic, instantiated twice (A and B).

Test Plan:
- Load-use: ResultSrcE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle. Rs1D=0 with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> Stall F/D/E/M=1 and FlushW=1 for exactly 3 cycles; the FSM returns to RUN; a PCSrcE held during the wait produces its flush on the release cycle.
- Bypass hold: RegWriteW=1, RdW=7, ResultW=0xDEADBEEF at wait entry; Rs2E=7 -> ForwardBE=11 and HeldResultE=0xDEADBEEF through the wait and the release cycle; ForwardBE=00 after E advances.
- Timeout: MEM_TIMEOUT=4, MemReadyM held at 0 -> MemTimeout=1 on the 4th wait cycle; it stays set after MemReadyM=1 and clears only on reset.
- Reset mid-wait: rst_n=0 while in WAIT -> state RUN, hold valid=0, MemTimeout=0, Flush*=1 while low. HAZARD_PERF_EN build: StallCount=3 after the memory-wait scenario.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_HOLD = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand EX forwarding priority: M stage, then bypass hold register, then W stage.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic       hold_valid_i,
    input  logic [4:0] hold_rd_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   sel_o
);

    // x0 never matches: the hold entry is only marked valid for a nonzero destination
    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != REG_ZERO) && (rd_m_i == rs_i)) begin
            sel_o = FWD_M;
        end else if (hold_valid_i && (hold_rd_i == rs_i)) begin
            sel_o = FWD_HOLD;
        end else if (reg_write_w_i && (rd_w_i != REG_ZERO) && (rd_w_i == rs_i)) begin
            sel_o = FWD_W;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline stall/flush/forward controller with memory-wait FSM and WB bypass hold.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [WIDTH-1:0] ResultW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [WIDTH-1:0] HeldResultE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [31:0]      StallCount,
    output logic [31:0]      FlushCount
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    hz_state_t        state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             hold_valid_q, hold_valid_d;
    logic [4:0]       hold_rd_q, hold_rd_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             mem_stall_s;
    logic             lw_stall_s;
    fwd_sel_t         fwd_a_s, fwd_b_s;

    // The memory stall is visible in the very cycle the unfinished request appears
    always_comb begin
        mem_stall_s = 1'b0;
        if (state_q == WAIT) begin
            mem_stall_s = !MemReadyM;
        end else begin
            mem_stall_s = MemReqM && !MemReadyM;
        end
        lw_stall_s = ResultSrcE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Wait FSM, saturating wait counter, sticky timeout and bypass capture
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = 16'd0;
                if (MemReqM && !MemReadyM) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else begin
                    state_d = WAIT;
                    if (wait_cnt_q != TIMEOUT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if (wait_cnt_d == TIMEOUT_LIMIT) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
        // W keeps retiring into the stalled pipe only on the entry cycle, so grab it then
        if ((state_q == RUN) && mem_stall_s) begin
            hold_valid_d = RegWriteW && (RdW != REG_ZERO);
            hold_rd_d    = RdW;
            hold_data_d  = ResultW;
        end else if (!mem_stall_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wait_cnt_q   <= 16'd0;
            timeout_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= REG_ZERO;
            hold_data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // Stall/flush resolution: memory wait beats branch beats load-use
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = 1'b0;
        end
    end

    hazard_fwd_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .hold_valid_i  (hold_valid_q),
        .hold_rd_i     (hold_rd_q),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .hold_valid_i  (hold_valid_q),
        .hold_rd_i     (hold_rd_q),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b_s)
    );

    assign ForwardAE   = rst_n ? fwd_a_s : FWD_RF;
    assign ForwardBE   = rst_n ? fwd_b_s : FWD_RF;
    assign HeldResultE = hold_data_q;
    assign MemTimeout  = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count only stalls and flushes that actually took effect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (mem_stall_s || (lw_stall_s && !PCSrcE)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (PCSrcE && !mem_stall_s) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 32'd0;
    assign FlushCount = 32'd0;
`endif

endmodule
